// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU encodings used across pipeline stages
package cpu_pkg;

  localparam int DATA_W = 8;

  // Writeback source select carried on MemToReg
  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'b00,
    WB_SRC_MEM = 2'b01,
    WB_SRC_IN  = 2'b10,
    WB_SRC_PC  = 2'b11
  } wb_src_e;

endpackage

// File: rtl/wb_out_fifo.sv
// rtl/wb_out_fifo.sv - output-port queue; DEPTH-entry ring with WB_OUT_FIFO_EN, else one holding register
module wb_out_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [DATA_W-1:0]       push_data_i,
  input  logic                    pop_ready_i,
  output logic [DATA_W-1:0]       data_o,
  output logic                    valid_o,
  output logic                    full_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic push_ok;
  logic pop_ok;

`ifdef WB_OUT_FIFO_EN
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;

  assign full_o  = (count_q == CW'(DEPTH));
  assign valid_o = (count_q != '0);
  // A full queue never accepts a push, even when the head pops on the same edge
  assign push_ok = push_i && !full_o;
  assign pop_ok  = valid_o && pop_ready_i;

  always_comb begin
    wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_ok  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_data_i;
  end

  assign data_o  = valid_o ? mem_q[rptr_q] : '0;
  assign count_o = count_q;
`else
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              vld_q, vld_d;

  assign full_o  = vld_q;
  assign valid_o = vld_q;
  assign push_ok = push_i && !vld_q;
  assign pop_ok  = vld_q && pop_ready_i;

  always_comb begin
    vld_d  = vld_q;
    hold_d = hold_q;
    if (pop_ok) vld_d = 1'b0;
    if (push_ok) begin
      vld_d  = 1'b1;
      hold_d = push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      vld_q  <= vld_d;
      hold_q <= hold_d;
    end
  end

  assign data_o  = vld_q ? hold_q : '0;
  assign count_o = CW'(vld_q);
`endif

endmodule

// File: rtl/wb_io_stage.sv
// rtl/wb_io_stage.sv - writeback mux, register-file write port and output-port queue
// Queue depth is honoured only when WB_OUT_FIFO_EN is defined.
module wb_io_stage
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       pc_plus1,
  input  logic [1:0]              RegDistidx,
  input  logic [DATA_W-1:0]       Rd2,
  input  logic [DATA_W-1:0]       ALU_res,
  input  logic [DATA_W-1:0]       data_B,
  input  logic [1:0]              MemToReg,
  input  logic                    RegWrite,
  input  logic [DATA_W-1:0]       IP,
  input  logic                    IO_Write,
  output logic                    rf_we,
  output logic [1:0]              rf_waddr,
  output logic [DATA_W-1:0]       rf_wdata,
  output logic [DATA_W-1:0]       fw_val,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    stall_req,
  output logic [$clog2(DEPTH):0]  out_count
);

  wb_src_e wb_src;
  logic    q_full;

  assign wb_src = wb_src_e'(MemToReg);

  always_comb begin
    rf_wdata = ALU_res;
    case (wb_src)
      WB_SRC_ALU: rf_wdata = ALU_res;
      WB_SRC_MEM: rf_wdata = data_B;
      WB_SRC_IN:  rf_wdata = IP;
      WB_SRC_PC:  rf_wdata = pc_plus1;
      default:    rf_wdata = ALU_res;
    endcase
  end

  // Register writes proceed during a stall; only the I/O push is held back
  assign rf_we     = RegWrite;
  assign rf_waddr  = RegDistidx;
  assign fw_val    = rf_wdata;
  assign stall_req = IO_Write && q_full;

  wb_out_fifo #(
    .DEPTH(DEPTH)
  ) u_out_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (IO_Write),
    .push_data_i (Rd2),
    .pop_ready_i (out_ready),
    .data_o      (out_data),
    .valid_o     (out_valid),
    .full_o      (q_full),
    .count_o     (out_count)
  );

endmodule

// File: tb/tb_wb_io_stage.sv
// tb/tb_wb_io_stage.sv - directed self-checking bench for wb_io_stage (FIFO or holding-register build)
module tb_wb_io_stage;

  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst;
  logic [7:0]             pc_plus1;
  logic [1:0]             RegDistidx;
  logic [7:0]             Rd2;
  logic [7:0]             ALU_res;
  logic [7:0]             data_B;
  logic [1:0]             MemToReg;
  logic                   RegWrite;
  logic [7:0]             IP;
  logic                   IO_Write;
  logic                   rf_we;
  logic [1:0]             rf_waddr;
  logic [7:0]             rf_wdata;
  logic [7:0]             fw_val;
  logic [7:0]             out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   stall_req;
  logic [$clog2(DEPTH):0] out_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  wb_io_stage #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_plus1   (pc_plus1),
    .RegDistidx (RegDistidx),
    .Rd2        (Rd2),
    .ALU_res    (ALU_res),
    .data_B     (data_B),
    .MemToReg   (MemToReg),
    .RegWrite   (RegWrite),
    .IP         (IP),
    .IO_Write   (IO_Write),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .fw_val     (fw_val),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .stall_req  (stall_req),
    .out_count  (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc_plus1 = 8'h44; RegDistidx = 2'd2; Rd2 = 8'h00; ALU_res = 8'h11;
    data_B = 8'h22; MemToReg = 2'b10; RegWrite = 1'b1; IP = 8'h33; IO_Write = 1'b0; out_ready = 1'b0;
    #3;
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    vec_cnt++; if (out_count !== 3'd0) begin err_cnt++; $display("FAIL reset_count got %0d exp 0", out_count); end
    vec_cnt++; if (out_data !== 8'h00) begin err_cnt++; $display("FAIL reset_data got %h exp 00", out_data); end
    vec_cnt++; if (stall_req !== 1'b0) begin err_cnt++; $display("FAIL reset_stall got %b exp 0", stall_req); end
    vec_cnt++; if (rf_wdata !== 8'h33) begin err_cnt++; $display("FAIL reset_rf_wdata got %h exp 33", rf_wdata); end
    vec_cnt++; if (rf_we !== 1'b1 || rf_waddr !== 2'd2) begin err_cnt++; $display("FAIL reset_rf_port got we=%b addr=%0d exp we=1 addr=2", rf_we, rf_waddr); end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_wb_mux();
    logic [7:0] exp_tab [4];
    exp_tab[0] = 8'h11; exp_tab[1] = 8'h22; exp_tab[2] = 8'h33; exp_tab[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      MemToReg = 2'(i); RegDistidx = 2'(3 - i); RegWrite = i[0];
      #1;
      vec_cnt++; if (rf_wdata !== exp_tab[i]) begin err_cnt++; $display("FAIL mux_sel%0d got %h exp %h", i, rf_wdata, exp_tab[i]); end
      vec_cnt++; if (fw_val !== exp_tab[i]) begin err_cnt++; $display("FAIL fw_val_sel%0d got %h exp %h", i, fw_val, exp_tab[i]); end
      vec_cnt++; if (rf_waddr !== 2'(3 - i) || rf_we !== i[0]) begin err_cnt++; $display("FAIL rf_port_sel%0d got we=%b addr=%0d", i, rf_we, rf_waddr); end
    end
    RegWrite = 1'b0; MemToReg = 2'b00;
  endtask

  task automatic test_single_push();
    IO_Write = 1'b1; Rd2 = 8'hA5; out_ready = 1'b0;
    #1;
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL single_pre_valid got %b exp 0", out_valid); end
    step();
    IO_Write = 1'b0; Rd2 = 8'h00;
    #1;
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL single_valid got %b exp 1", out_valid); end
    vec_cnt++; if (out_data !== 8'hA5) begin err_cnt++; $display("FAIL single_data got %h exp a5", out_data); end
    vec_cnt++; if (out_count !== 3'd1) begin err_cnt++; $display("FAIL single_count got %0d exp 1", out_count); end
    step(); step(); step();
    vec_cnt++; if (out_data !== 8'hA5 || out_valid !== 1'b1) begin err_cnt++; $display("FAIL single_hold got %h/%b exp a5/1", out_data, out_valid); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    vec_cnt++; if (out_valid !== 1'b0 || out_count !== 3'd0) begin err_cnt++; $display("FAIL single_pop got valid=%b count=%0d exp 0/0", out_valid, out_count); end
  endtask

`ifdef WB_OUT_FIFO_EN
  task automatic test_fill_stall_drain();
    logic [7:0] exp_tab [3];
    exp_tab[0] = 8'h03; exp_tab[1] = 8'h04; exp_tab[2] = 8'h05;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      IO_Write = 1'b1; Rd2 = 8'(i);
      #1;
      vec_cnt++; if (stall_req !== 1'b0) begin err_cnt++; $display("FAIL fill_stall%0d got %b exp 0", i, stall_req); end
      step();
    end
    Rd2 = 8'h05;
    #1;
    vec_cnt++; if (stall_req !== 1'b1) begin err_cnt++; $display("FAIL full_stall got %b exp 1", stall_req); end
    vec_cnt++; if (out_count !== 3'd4) begin err_cnt++; $display("FAIL full_count got %0d exp 4", out_count); end
    step();
    vec_cnt++; if (out_count !== 3'd4 || stall_req !== 1'b1) begin err_cnt++; $display("FAIL stalled_push got count=%0d stall=%b exp 4/1", out_count, stall_req); end
    out_ready = 1'b1;
    #1;
    vec_cnt++; if (stall_req !== 1'b1 || out_data !== 8'h01) begin err_cnt++; $display("FAIL full_pop_push got stall=%b data=%h exp 1/01", stall_req, out_data); end
    step();
    vec_cnt++; if (out_count !== 3'd3) begin err_cnt++; $display("FAIL full_pop_count got %0d exp 3", out_count); end
    vec_cnt++; if (out_data !== 8'h02 || stall_req !== 1'b0) begin err_cnt++; $display("FAIL drain_2 got data=%h stall=%b exp 02/0", out_data, stall_req); end
    step();
    IO_Write = 1'b0;
    #1;
    vec_cnt++; if (out_count !== 3'd3) begin err_cnt++; $display("FAIL push_pop_count got %0d exp 3", out_count); end
    for (int k = 0; k < 3; k++) begin
      vec_cnt++; if (out_data !== exp_tab[k] || out_valid !== 1'b1) begin err_cnt++; $display("FAIL drain_%0d got %h exp %h", k + 3, out_data, exp_tab[k]); end
      step();
    end
    vec_cnt++; if (out_valid !== 1'b0 || out_count !== 3'd0) begin err_cnt++; $display("FAIL drained got valid=%b count=%0d exp 0/0", out_valid, out_count); end
    out_ready = 1'b0;
  endtask
`else
  task automatic test_holding_b2b();
    out_ready = 1'b0;
    IO_Write = 1'b1; Rd2 = 8'h5A;
    #1;
    vec_cnt++; if (stall_req !== 1'b0) begin err_cnt++; $display("FAIL hold_first_stall got %b exp 0", stall_req); end
    step();
    Rd2 = 8'h6B;
    #1;
    vec_cnt++; if (stall_req !== 1'b1) begin err_cnt++; $display("FAIL hold_second_stall got %b exp 1", stall_req); end
    vec_cnt++; if (out_count !== 3'd1 || out_data !== 8'h5A) begin err_cnt++; $display("FAIL hold_state got count=%0d data=%h exp 1/5a", out_count, out_data); end
    step();
    vec_cnt++; if (stall_req !== 1'b1 || out_data !== 8'h5A) begin err_cnt++; $display("FAIL hold_stall_held got stall=%b data=%h exp 1/5a", stall_req, out_data); end
    out_ready = 1'b1;
    #1;
    vec_cnt++; if (stall_req !== 1'b1) begin err_cnt++; $display("FAIL hold_pop_edge_stall got %b exp 1", stall_req); end
    step();
    vec_cnt++; if (out_count !== 3'd0 || out_valid !== 1'b0) begin err_cnt++; $display("FAIL hold_no_push_on_pop got count=%0d valid=%b exp 0/0", out_count, out_valid); end
    vec_cnt++; if (stall_req !== 1'b0) begin err_cnt++; $display("FAIL hold_retry_stall got %b exp 0", stall_req); end
    step();
    IO_Write = 1'b0; out_ready = 1'b0;
    #1;
    vec_cnt++; if (out_data !== 8'h6B || out_count !== 3'd1) begin err_cnt++; $display("FAIL hold_retry_data got %h count=%0d exp 6b/1", out_data, out_count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL hold_final_pop got %b exp 0", out_valid); end
  endtask
`endif

  task automatic test_reset_mid();
    int n;
`ifdef WB_OUT_FIFO_EN
    n = 3;
`else
    n = 1;
`endif
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      IO_Write = 1'b1; Rd2 = 8'(8'h70 + i);
      step();
    end
    IO_Write = 1'b0;
    #1;
    vec_cnt++; if (out_count !== 3'(n)) begin err_cnt++; $display("FAIL mid_pre_count got %0d exp %0d", out_count, n); end
    rst = 1'b0; MemToReg = 2'b00; ALU_res = 8'h11;
    #1;
    vec_cnt++; if (out_valid !== 1'b0 || out_count !== 3'd0) begin err_cnt++; $display("FAIL mid_reset got valid=%b count=%0d exp 0/0", out_valid, out_count); end
    vec_cnt++; if (out_data !== 8'h00) begin err_cnt++; $display("FAIL mid_reset_data got %h exp 00", out_data); end
    vec_cnt++; if (rf_wdata !== 8'h11) begin err_cnt++; $display("FAIL mid_reset_rf got %h exp 11", rf_wdata); end
    step();
    rst = 1'b1;
    step();
    vec_cnt++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_count !== 3'd0) begin err_cnt++; $display("FAIL post_reset got valid=%b data=%h count=%0d exp 0/00/0", out_valid, out_data, out_count); end
  endtask

  initial begin
    test_reset();
    test_wb_mux();
    test_single_push();
`ifdef WB_OUT_FIFO_EN
    test_fill_stall_drain();
`else
    test_holding_b2b();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/wb_io_stage.md
WB_IO_STAGE -- requirements
Module: wb_io_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output-queue entry count; power of 2, minimum 2.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have pc_plus1  input  8  return address from the MEM/WB register.
REQ-005 SHALL have RegDistidx  input  2  destination register index.
REQ-006 SHALL have Rd2  input  8  source data for an I/O write.
REQ-007 SHALL have ALU_res  input  8  ALU result.
REQ-008 SHALL have data_B  input  8  data-memory read data.
REQ-009 SHALL have MemToReg  input  2  writeback source select.
REQ-010 SHALL have RegWrite  input  1  register-file write request.
REQ-011 SHALL have IP  input  8  sampled input-port value.
REQ-012 SHALL have IO_Write  input  1  output-port write request.
REQ-013 SHALL have rf_we, rf_waddr, rf_wdata  output  1/2/8  register-file write port.
REQ-014 SHALL have fw_val  output  8  forwarding value; equal to rf_wdata.
REQ-015 SHALL have out_data, out_valid  output  8/1  output-port data and valid.
REQ-016 SHALL have out_ready  input  1  external consumer accepts out_data.
REQ-017 SHALL have stall_req  output  1  freeze request to the hazard unit.
REQ-018 SHALL have out_count  output  clog2(DEPTH)+1  queued entry count.

Function
REQ-019 SHALL drive rf_wdata combinationally: MemToReg 00 -> ALU_res, 01 -> data_B, 10 -> IP, 11 -> pc_plus1.
REQ-020 SHALL drive rf_we = RegWrite and rf_waddr = RegDistidx combinationally; rf_we is not gated by stall_req.
REQ-021 SHALL push Rd2 into the output queue at a clock edge when IO_Write=1 and the queue is not full.
REQ-022 SHALL pop the head entry at a clock edge when out_valid=1 and out_ready=1.
REQ-023 SHALL drive out_valid=1 whenever out_count>0, with out_data showing the head entry.
REQ-024 SHALL present a pushed value on out_data one cycle after the push edge when the queue was empty.
REQ-025 SHALL drive stall_req = IO_Write AND full combinationally; a stalled push is not enqueued and is retried on a later cycle.
REQ-026 SHALL, when full, reject a push even if a pop occurs on the same edge; stall_req stays 1 for that cycle.
REQ-027 SHALL, when not full and not empty, perform a simultaneous push and pop with out_count unchanged.
REQ-028 SHALL wrap read and write pointers modulo DEPTH.
REQ-029 SHALL hold out_data stable while out_valid=1 and out_ready=0.

Reset
REQ-030 SHALL, while rst=0, clear the pointers and out_count to 0, force out_valid=0, and force out_data to 0.
REQ-031 SHALL discard queued entries on reset mid-operation; combinational rf outputs continue to follow their inputs.

Configuration
REQ-032 SHALL, with WB_OUT_FIFO_EN defined, implement the DEPTH-entry queue.
REQ-033 SHALL, without WB_OUT_FIFO_EN, implement a single holding register: full when out_count=1, and no push while holding even if a pop occurs on the same edge.

Structure
REQ-034 SHALL take the MemToReg encodings (WB_SRC_ALU, WB_SRC_MEM, WB_SRC_IN, WB_SRC_PC) from the shared cpu_pkg package.
REQ-035 SHALL implement the queue as sub-module wb_out_fifo, instantiated once.

Verification
REQ-036 SHALL cover: MemToReg=00/01/10/11 with ALU_res=0x11, data_B=0x22, IP=0x33, pc_plus1=0x44 -> rf_wdata 0x11/0x22/0x33/0x44.
REQ-037 SHALL cover: IO_Write with Rd2=0xA5, queue empty, out_ready=0 -> out_valid=1 and out_data=0xA5 next cycle, held stable.
REQ-038 SHALL cover: 4 pushes (0x01..0x04) with out_ready=0, then a 5th with Rd2=0x05 -> stall_req=1, out_count=4; then out_ready=1 -> drain 0x01..0x04 in order, and 0x05 is enqueued once not full.
REQ-039 SHALL cover: full queue with push and pop on the same edge -> pop accepted, push rejected, out_count goes 4->3.
REQ-040 SHALL cover: reset asserted with 3 entries queued -> out_valid=0 and out_count=0 immediately; no stale data after release.
REQ-041 SHALL cover: build without WB_OUT_FIFO_EN, two back-to-back IO_Write -> second cycle stall_req=1 until the first value pops.
